// File: rtl/ring_arb_pkg.sv
// rtl/ring_arb_pkg.sv - shared FSM encodings and defaults for the ring round-robin arbiter
package ring_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_ring_ptr.sv
// rtl/rr_ring_ptr.sv - one-hot ring priority pointer, loads the successor of a given owner
module rr_ring_ptr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] owner,
    output logic [N-1:0] ptr
);

    logic [N-1:0] succ;
    logic [N-1:0] reset_val;

    // Successor of owner in the ring: rotate left by one, N-1 wraps to 0.
    assign succ      = {owner[N-2:0], owner[N-1]};
    assign reset_val = {{(N-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= reset_val;
        end else if (load) begin
            ptr <= succ;
        end
    end

endmodule

// File: rtl/ring_rr_arbiter.sv
// rtl/ring_rr_arbiter.sv - round-robin arbiter with one-hot ring pointer and bounded hold
module ring_rr_arbiter
    import ring_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    localparam int ID_W    = $clog2(N),
    localparam int CNT_W   = $clog2(MAX_HOLD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id,
    output logic            busy,
    output logic            timeout
);

    localparam logic [ID_W:0]    N_W      = (ID_W+1)'(N);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e       state, state_d;
    logic [N-1:0]     grant_d;
    logic [ID_W-1:0]  id_d;
    logic [CNT_W-1:0] hold_cnt, cnt_d;
    logic             timeout_d;
    logic             ptr_load;
    logic [N-1:0]     ptr;

    logic [N-1:0]     base;
    logic [N-1:0]     masked;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [ID_W-1:0]  base_idx;
    logic [ID_W-1:0]  off;
    logic [ID_W:0]    sum;
    logic             found;
    logic [ID_W-1:0]  win_id;
    logic [N-1:0]     win_oh;

    rr_ring_ptr #(.N(N)) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .load  (ptr_load),
        .owner (grant),
        .ptr   (ptr)
    );

    // In GRANT the scan starts just past the owner, which is also where the
    // pointer lands on release/timeout; the owner itself is masked out.
    always_comb begin
        base   = (state == GRANT) ? {grant[N-2:0], grant[N-1]} : ptr;
        masked = req & ~grant;
        base_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (base[i]) base_idx = ID_W'(i);
        end
        dbl = {masked, masked} >> base_idx;
        rot = dbl[N-1:0];
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = ID_W'(i);
        end
        found = |masked;
        sum   = {1'b0, base_idx} + {1'b0, off};
        if (sum >= N_W) sum = sum - N_W;
        win_id = sum[ID_W-1:0];
        win_oh = '0;
        win_oh[win_id] = found;
    end

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        id_d      = grant_id;
        cnt_d     = hold_cnt;
        timeout_d = 1'b0;
        ptr_load  = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (found) begin
                    grant_d = win_oh;
                    id_d    = win_id;
                    state_d = GRANT;
                end else begin
                    grant_d = '0;
                    id_d    = '0;
                end
            end
            GRANT: begin
                if (~|(req & grant)) begin
                    ptr_load = 1'b1;
                    cnt_d    = '0;
                    if (found) begin
                        grant_d = win_oh;
                        id_d    = win_id;
                    end else begin
                        grant_d = '0;
                        id_d    = '0;
                        state_d = IDLE;
                    end
                end else if (hold_cnt != CNT_LAST) begin
                    cnt_d = hold_cnt + CNT_W'(1);
                end else if (found) begin
                    grant_d   = win_oh;
                    id_d      = win_id;
                    ptr_load  = 1'b1;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                id_d    = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_d;
            grant    <= grant_d;
            grant_id <= id_d;
            hold_cnt <= cnt_d;
            timeout  <= timeout_d;
        end
    end

    assign busy = |grant;

endmodule
